// File: rtl/ahb2apb_if.sv
// AHB-Lite slave / APB master signal bundle for the AHB-to-APB bridge.
// The slave modport is the bridge's view; the master modport is the surrounding bus side.
interface ahb2apb_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [15:0] PSEL;
  logic        PENABLE;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA,
    output HRDATA, HREADYOUT, HRESP,
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA,
    input  HRDATA, HREADYOUT, HRESP,
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge for 16 peripherals: address decode to one-hot PSEL,
// SETUP/ACCESS sequencing, PREADY timeout abort and two-cycle AHB ERROR response.
module ahb2apb_bridge #(
  parameter int unsigned SLOT_LSB = 12,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic       PCLK,
  input  logic       PRST_N,
  ahb2apb_if.slave   bus
);
  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned NSLV   = 16;
  localparam int unsigned SLOT_W = 4;
  localparam int unsigned CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
  } state_e;

  state_e            state_q, state_d;
  logic [NSLV-1:0]   psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [AW-1:0]     paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DW-1:0]     pwdata_q, pwdata_d;
  logic [DW-1:0]     hrdata_q, hrdata_d;
  logic              hreadyout_q, hreadyout_d;
  logic [1:0]        hresp_q, hresp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept_c;
  logic              timeout_c;
  logic              unused_htrans;

  assign unused_htrans = bus.HTRANS[0];

  // Next-state and registered-output computation; outputs follow the state being entered.
  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    hrdata_d  = hrdata_q;
    cnt_d     = cnt_q;
    accept_c  = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    timeout_c = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT));

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept_c) begin
          paddr_d  = bus.HADDR;
          pwrite_d = bus.HWRITE;
          state_d  = bus.HWRITE ? S_WDATA : S_SETUP;
        end
      end
      S_WDATA: begin
        pwdata_d = bus.HWDATA;
        state_d  = S_SETUP;
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (bus.PREADY) begin
          if (bus.PSLVERR) begin
            state_d = S_ERR1;
          end else begin
            if (!pwrite_q) hrdata_d = bus.PRDATA;
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (timeout_c) state_d = S_ERR1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_SETUP) cnt_d = '0;

    psel_d = '0;
    if (state_d == S_SETUP || state_d == S_ACCESS)
      psel_d = NSLV'(1) << paddr_d[SLOT_LSB +: SLOT_W];
    penable_d   = (state_d == S_ACCESS);
    hreadyout_d = (state_d inside {S_IDLE, S_DONE, S_ERR2});
    hresp_d     = (state_d inside {S_ERR1, S_ERR2}) ? RESP_ERROR : RESP_OKAY;
  end

  always_ff @(posedge PCLK) begin
    if (!PRST_N) begin
      state_q     <= S_IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      hrdata_q    <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= RESP_OKAY;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      hrdata_q    <= hrdata_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.HRDATA    = hrdata_q;
  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;
endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed plus randomized transfers through the AHB-to-APB bridge, checked against a
// transaction-level expectation; a second instance with TIMEOUT=4 covers the PREADY abort.
module tb_ahb2apb_bridge;
  localparam int unsigned SLOT_LSB = 12;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ahb2apb_if bus ();
  ahb2apb_if bus_to ();

  ahb2apb_bridge #(.SLOT_LSB(SLOT_LSB), .TIMEOUT(255)) u_dut (
    .PCLK(clk), .PRST_N(rst_n), .bus(bus));
  ahb2apb_bridge #(.SLOT_LSB(SLOT_LSB), .TIMEOUT(4)) u_dut_to (
    .PCLK(clk), .PRST_N(rst_n), .bus(bus_to));

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_hrdata;
  logic [31:0] exp_paddr;
  logic        exp_pwrite;
  logic [31:0] exp_pwdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Non-transfer address-phase noise: HTRANS IDLE or BUSY never starts anything.
  task automatic idle_noise();
    bus.HSEL   = 1'($urandom_range(0, 1));
    bus.HTRANS = {1'b0, 1'($urandom_range(0, 1))};
    bus.HADDR  = $urandom;
    bus.HWRITE = 1'($urandom_range(0, 1));
    bus.HREADY = 1'b1;
  endtask

  task automatic chk_reset(input string pfx, input logic [15:0] psel, input logic pen,
                           input logic [31:0] paddr, input logic pwr, input logic [31:0] pwd,
                           input logic [31:0] hrd, input logic hro, input logic [1:0] hrs);
    chk({pfx, "_psel"}, 32'(psel), 32'h0);
    chk({pfx, "_penable"}, 32'(pen), 32'h0);
    chk({pfx, "_paddr"}, paddr, 32'h0);
    chk({pfx, "_pwrite"}, 32'(pwr), 32'h0);
    chk({pfx, "_pwdata"}, pwd, 32'h0);
    chk({pfx, "_hrdata"}, hrd, 32'h0);
    chk({pfx, "_hreadyout"}, 32'(hro), 32'h1);
    chk({pfx, "_hresp"}, 32'(hrs), 32'h0);
  endtask

  // One complete AHB transfer: address phase, optional write-data stage, SETUP,
  // nwait+1 ACCESS cycles, then OKAY completion or the two-cycle ERROR response.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input int nwait, input logic err);
    logic [3:0]  slot;
    logic [15:0] exp_sel;
    slot    = addr[SLOT_LSB +: 4];
    exp_sel = 16'(2 ** slot);

    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR  = addr;
    bus.HWRITE = wr;
    bus.HREADY = 1'b1;
    tick();
    idle_noise();
    exp_paddr  = addr;
    exp_pwrite = wr;

    if (wr) begin
      chk("wdata_hreadyout", 32'(bus.HREADYOUT), 32'h0);
      chk("wdata_psel", 32'(bus.PSEL), 32'h0);
      bus.HWDATA = wdata;
      tick();
      bus.HWDATA = $urandom;
      exp_pwdata = wdata;
    end

    chk("setup_psel", 32'(bus.PSEL), 32'(exp_sel));
    chk("setup_penable", 32'(bus.PENABLE), 32'h0);
    chk("setup_hreadyout", 32'(bus.HREADYOUT), 32'h0);
    chk("setup_paddr", bus.PADDR, exp_paddr);
    chk("setup_pwrite", 32'(bus.PWRITE), 32'(exp_pwrite));
    chk("setup_pwdata", bus.PWDATA, exp_pwdata);
    tick();

    for (int i = 0; i <= nwait; i++) begin
      chk("access_psel", 32'(bus.PSEL), 32'(exp_sel));
      chk("access_penable", 32'(bus.PENABLE), 32'h1);
      chk("access_hreadyout", 32'(bus.HREADYOUT), 32'h0);
      chk("access_paddr", bus.PADDR, exp_paddr);
      chk("access_pwdata", bus.PWDATA, exp_pwdata);
      bus.PREADY  = (i == nwait);
      bus.PSLVERR = (i == nwait) ? err : 1'($urandom_range(0, 1));
      bus.PRDATA  = (i == nwait) ? rdata : $urandom;
      tick();
    end
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = $urandom;

    if (!err) begin
      if (!wr) exp_hrdata = rdata;
      chk("done_hreadyout", 32'(bus.HREADYOUT), 32'h1);
      chk("done_hresp", 32'(bus.HRESP), 32'h0);
      chk("done_psel", 32'(bus.PSEL), 32'h0);
      chk("done_penable", 32'(bus.PENABLE), 32'h0);
      chk("done_hrdata", bus.HRDATA, exp_hrdata);
    end else begin
      chk("err1_hreadyout", 32'(bus.HREADYOUT), 32'h0);
      chk("err1_hresp", 32'(bus.HRESP), 32'h1);
      chk("err1_psel", 32'(bus.PSEL), 32'h0);
      chk("err1_penable", 32'(bus.PENABLE), 32'h0);
      chk("err1_hrdata", bus.HRDATA, exp_hrdata);
      tick();
      chk("err2_hreadyout", 32'(bus.HREADYOUT), 32'h1);
      chk("err2_hresp", 32'(bus.HRESP), 32'h1);
      chk("err2_psel", 32'(bus.PSEL), 32'h0);
      // A transfer offered while ERROR is still showing must be dropped.
      bus.HSEL   = 1'b1;
      bus.HTRANS = 2'b10;
      bus.HADDR  = $urandom;
      bus.HWRITE = 1'($urandom_range(0, 1));
      tick();
      idle_noise();
      chk("post_err_hreadyout", 32'(bus.HREADYOUT), 32'h1);
      chk("post_err_hresp", 32'(bus.HRESP), 32'h0);
      chk("post_err_psel", 32'(bus.PSEL), 32'h0);
      chk("post_err_paddr", bus.PADDR, exp_paddr);
    end
  endtask

  initial begin
    int to_cycles;
    rst_n = 1'b0;
    bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
    bus.HREADY = 1'b1; bus.HWDATA = '0; bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
    bus_to.HSEL = 1'b0; bus_to.HADDR = '0; bus_to.HTRANS = 2'b00; bus_to.HWRITE = 1'b0;
    bus_to.HREADY = 1'b1; bus_to.HWDATA = '0; bus_to.PRDATA = '0; bus_to.PREADY = 1'b0;
    bus_to.PSLVERR = 1'b0;
    exp_hrdata = '0; exp_paddr = '0; exp_pwrite = 1'b0; exp_pwdata = '0;

    tick();
    tick();
    chk_reset("rst", bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWRITE, bus.PWDATA,
              bus.HRDATA, bus.HREADYOUT, bus.HRESP);
    chk_reset("rst_to", bus_to.PSEL, bus_to.PENABLE, bus_to.PADDR, bus_to.PWRITE,
              bus_to.PWDATA, bus_to.HRDATA, bus_to.HREADYOUT, bus_to.HRESP);
    rst_n = 1'b1;
    tick();

    // Directed scenarios from the block's intended use.
    xfer(32'h0000_3004, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    tick();
    xfer(32'h0000_F010, 1'b1, 32'h1234_5678, $urandom, 0, 1'b0);
    tick();
    xfer(32'h0000_7008, 1'b0, 32'h0, 32'hCAFE_0001, 5, 1'b0);
    tick();
    xfer(32'h0000_1000, 1'b0, 32'h0, 32'hBAD0_BAD0, 1, 1'b1);
    xfer(32'h0000_A000, 1'b1, 32'h5555_AAAA, $urandom, 2, 1'b1);

    // Gated address phases: HREADY low, BUSY, HSEL low.
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HREADY = 1'b0; bus.HADDR = 32'h0000_4000;
    tick();
    chk("hready_low_psel", 32'(bus.PSEL), 32'h0);
    chk("hready_low_hreadyout", 32'(bus.HREADYOUT), 32'h1);
    bus.HREADY = 1'b1; bus.HTRANS = 2'b01;
    tick();
    chk("busy_psel", 32'(bus.PSEL), 32'h0);
    chk("busy_paddr", bus.PADDR, exp_paddr);
    bus.HSEL = 1'b0; bus.HTRANS = 2'b10;
    tick();
    chk("hsel_low_hreadyout", 32'(bus.HREADYOUT), 32'h1);
    chk("hsel_low_paddr", bus.PADDR, exp_paddr);
    bus.HTRANS = 2'b00;

    // Back-to-back reads issued from the completion cycle.
    xfer(32'h0000_2000, 1'b0, 32'h0, 32'h0BAD_F00D, 0, 1'b0);
    xfer(32'h0000_6ABC, 1'b0, 32'h0, 32'h1357_9BDF, 1, 1'b0);
    xfer(32'h0000_E004, 1'b1, 32'hFEED_FACE, $urandom, 0, 1'b0);

    // Randomized traffic with random idle gaps.
    for (int t = 0; t < 60; t++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        idle_noise();
        tick();
        chk("gap_hreadyout", 32'(bus.HREADYOUT), 32'h1);
        chk("gap_psel", 32'(bus.PSEL), 32'h0);
        chk("gap_hresp", 32'(bus.HRESP), 32'h0);
      end
      xfer($urandom, 1'($urandom_range(0, 1)), $urandom, $urandom,
           int'($urandom_range(0, 6)), ($urandom_range(0, 4) == 0));
    end
    tick();

    // Reset while in ACCESS aborts the transfer.
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = 32'h0000_5010;
    tick();
    idle_noise();
    chk("rstacc_setup_psel", 32'(bus.PSEL), 32'h0000_0020);
    tick();
    chk("rstacc_penable", 32'(bus.PENABLE), 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_hrdata = '0; exp_paddr = '0; exp_pwrite = 1'b0; exp_pwdata = '0;
    chk_reset("rstacc", bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWRITE, bus.PWDATA,
              bus.HRDATA, bus.HREADYOUT, bus.HRESP);
    tick();
    chk("rstacc_idle_psel", 32'(bus.PSEL), 32'h0);
    xfer(32'h0000_9000, 1'b0, 32'h0, 32'h2468_ACE0, 0, 1'b0);
    tick();

    // TIMEOUT=4 instance with PREADY stuck low.
    bus_to.HSEL = 1'b1; bus_to.HTRANS = 2'b10; bus_to.HWRITE = 1'b0;
    bus_to.HADDR = 32'h0000_2000; bus_to.PREADY = 1'b0;
    tick();
    bus_to.HSEL = 1'b0; bus_to.HTRANS = 2'b00;
    chk("to_setup_psel", 32'(bus_to.PSEL), 32'h0000_0004);
    tick();
    to_cycles = 0;
    while (bus_to.PENABLE === 1'b1 && to_cycles < 20) begin
      to_cycles++;
      tick();
    end
    chk("to_access_cycles", 32'(to_cycles), 32'd4);
    chk("to_err1_hresp", 32'(bus_to.HRESP), 32'h1);
    chk("to_err1_hreadyout", 32'(bus_to.HREADYOUT), 32'h0);
    chk("to_err1_psel", 32'(bus_to.PSEL), 32'h0);
    tick();
    chk("to_err2_hresp", 32'(bus_to.HRESP), 32'h1);
    chk("to_err2_hreadyout", 32'(bus_to.HREADYOUT), 32'h1);
    tick();
    chk("to_idle_hresp", 32'(bus_to.HRESP), 32'h0);
    chk("to_idle_hrdata", bus_to.HRDATA, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
